// File: rtl/io_port_bridge_if.sv
// io_port_bridge_if
//   Groups the processor-side port signals and the device-side handshake
//   signals of the I/O port bridge.
//   slave  : the bridge itself (consumes OUT words, produces IN words)
//   master : the surroundings (processor + external device / testbench)
// Signals:
//   outPortData/outSignalEn   processor OUT word and strobe
//   inPortData/interruptSignal/inRead  processor IN word, pulse, acknowledge
//   devOutData/devOutValid/devOutReady  FIFO head to device (valid/ready)
//   devInData/devInValid/devInReady     device word into the bridge
//   outOverflow               sticky flag: an OUT word was dropped
interface io_port_bridge_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] outPortData;
  logic                  outSignalEn;
  logic [DATA_WIDTH-1:0] inPortData;
  logic                  interruptSignal;
  logic                  inRead;
  logic [DATA_WIDTH-1:0] devOutData;
  logic                  devOutValid;
  logic                  devOutReady;
  logic [DATA_WIDTH-1:0] devInData;
  logic                  devInValid;
  logic                  devInReady;
  logic                  outOverflow;

  modport slave (
    input  outPortData, outSignalEn, inRead, devOutReady, devInData, devInValid,
    output inPortData, interruptSignal, devOutData, devOutValid, devInReady,
           outOverflow
  );

  modport master (
    output outPortData, outSignalEn, inRead, devOutReady, devInData, devInValid,
    input  inPortData, interruptSignal, devOutData, devOutValid, devInReady,
           outOverflow
  );
endinterface

// File: rtl/io_port_bridge.sv
// io_port_bridge
//   External-device side of the processor I/O port.
//   Output path: processor OUT words are buffered in a show-ahead FIFO and
//   drained to the device over devOutValid/devOutReady. A word pushed while
//   the FIFO is full (and nothing pops that cycle) is dropped and sets the
//   sticky outOverflow flag.
//   Input path: a two-state FSM captures one device word into inPortData,
//   pulses interruptSignal for one cycle and refuses further words until
//   the processor acknowledges with inRead.
// Ports:
//   clk    system clock, all state on the rising edge
//   reset  asynchronous, active-low reset
//   bus    io_port_bridge_if.slave (see interface file for signal list)
module io_port_bridge #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  io_port_bridge_if.slave   bus
);

  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(OUT_DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } in_state_t;

  // Output FIFO
  logic [DATA_WIDTH-1:0] mem [OUT_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  ovf;
  logic                  not_empty;
  logic                  do_pop;
  logic                  do_push;

  assign not_empty = (count != '0);
  assign do_pop    = not_empty && bus.devOutReady;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
  assign do_push   = bus.outSignalEn && ((count < FULL) || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
      if (bus.outSignalEn && !do_push) ovf <= 1'b1;
    end
  end

  // Storage carries no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= bus.outPortData;
  end

  assign bus.devOutValid = not_empty;
  assign bus.devOutData  = not_empty ? mem[rd_ptr] : '0;
  assign bus.outOverflow = ovf;

  // Input FSM
  in_state_t             state_q;
  in_state_t             state_d;
  logic                  in_en;
  logic                  capture;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  irq;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_en && bus.devInValid) begin
          capture = 1'b1;
          state_d = PEND;
        end
      end
      PEND: begin
        // A device word offered here waits; it is taken in IDLE next cycle.
        if (bus.inRead) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // in_en holds devInReady low while reset is asserted and rises on the
  // first edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      in_en   <= 1'b0;
      in_data <= '0;
      irq     <= 1'b0;
    end else begin
      state_q <= state_d;
      in_en   <= 1'b1;
      irq     <= capture;
      if (capture) in_data <= bus.devInData;
    end
  end

  assign bus.devInReady      = in_en && (state_q == IDLE);
  assign bus.inPortData      = in_data;
  assign bus.interruptSignal = irq;

endmodule
